// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle control sequencer for a one-byte-instruction
// accumulator machine. The sequencer fetches from a synchronous-read memory,
// decodes, optionally reads an operand, then executes through an external ALU.
module exec_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    output logic [7:0] memAddr,
    input  logic [7:0] memData,
    output logic       memWrite,
    output logic [7:0] memWriteData,
    output logic [1:0] aluControl,
    output logic [7:0] aluDataInACC,
    output logic [7:0] aluDataIn,
    output logic [7:0] aluPc,
    input  logic [7:0] aluResult,
    output logic [7:0] pc,
    output logic [7:0] acc,
    output logic       halted
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_NAND  = 3'b001;
    localparam logic [2:0] OP_BNZ   = 3'b010;
    localparam logic [2:0] OP_SLT   = 3'b011;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_STORE = 3'b101;
    localparam logic [2:0] OP_LDI   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    logic [2:0] state;
    logic [7:0] ir;
    logic [2:0] opcode;
    logic [7:0] operand;

    assign opcode  = ir[7:5];
    assign operand = {3'b000, ir[4:0]};

    // State, instruction register and architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            pc    <= '0;
            acc   <= '0;
            ir    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) state <= S_FETCH;
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    // ir is not loaded yet, so the route is taken from memData.
                    ir <= memData;
                    case (memData[7:5])
                        OP_ADD, OP_NAND, OP_SLT, OP_LOAD: state <= S_READ;
                        OP_HALT:                          state <= S_HALT;
                        default:                          state <= S_EXEC;
                    endcase
                end
                S_READ: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    case (opcode)
                        OP_ADD, OP_NAND, OP_SLT: acc <= aluResult;
                        OP_LOAD:                 acc <= memData;
                        OP_LDI:                  acc <= operand;
                        default:                 acc <= acc;
                    endcase
                    if (opcode == OP_BNZ) pc <= aluResult;
                    else                  pc <= pc + 8'd1;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory and ALU control decoded from the current state and instruction.
    always_comb begin
        memAddr    = '0;
        memWrite   = 1'b0;
        aluControl = 2'b00;
        aluDataIn  = memData;
        case (state)
            S_FETCH: memAddr = pc;
            S_READ:  memAddr = operand;
            S_EXEC: begin
                memAddr  = operand;
                memWrite = (opcode == OP_STORE);
                if (opcode == OP_BNZ) aluDataIn = operand;
                case (opcode)
                    OP_ADD:  aluControl = 2'b00;
                    OP_NAND: aluControl = 2'b01;
                    OP_BNZ:  aluControl = 2'b10;
                    OP_SLT:  aluControl = 2'b11;
                    default: aluControl = 2'b00;
                endcase
            end
            default: memAddr = '0;
        endcase
    end

    assign memWriteData = acc;
    assign aluDataInACC = acc;
    assign aluPc        = pc;
    assign halted       = (state == S_HALT);

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: provides a synchronous-read memory
// and an ALU, and compares the DUT against an instruction-level model.
module tb_exec_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic [7:0] memAddr, memData, memWriteData;
    logic       memWrite, halted;
    logic [1:0] aluControl;
    logic [7:0] aluDataInACC, aluDataIn, aluPc, aluResult, pc, acc;

    exec_sequencer dut (
        .clk(clk), .reset(reset), .run(run),
        .memAddr(memAddr), .memData(memData),
        .memWrite(memWrite), .memWriteData(memWriteData),
        .aluControl(aluControl), .aluDataInACC(aluDataInACC),
        .aluDataIn(aluDataIn), .aluPc(aluPc), .aluResult(aluResult),
        .pc(pc), .acc(acc), .halted(halted)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] rmem [256];
    logic [7:0] rpc, racc;
    int         wexp = 0;
    int         wr_count = 0;
    int         tests = 0;
    int         failed = 0;

    // Memory with one-cycle read latency and a write port.
    always @(posedge clk) begin
        memData <= mem[memAddr];
        if (memWrite) mem[memAddr] <= memWriteData;
    end

    // ALU.
    always_comb begin
        case (aluControl)
            2'b00:   aluResult = aluDataInACC + aluDataIn;
            2'b01:   aluResult = ~(aluDataInACC & aluDataIn);
            2'b10:   aluResult = (aluDataInACC != 8'd0) ? aluDataIn : aluPc + 8'd1;
            default: aluResult = (aluDataInACC < aluDataIn) ? 8'd1 : 8'd0;
        endcase
    end

    // Count write strobe cycles.
    always @(negedge clk) if (memWrite === 1'b1) wr_count++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int a, input logic [7:0] v);
        mem[a]  = v;
        rmem[a] = v;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 256; i++) put(i, v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rpc  = 8'd0;
        racc = 8'd0;
    endtask

    task automatic start();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    // Executes up to max instructions, checking each against the model.
    task automatic exec_prog(input int max);
        logic [7:0] ins, opd;
        logic [2:0] op;
        logic [1:0] ectl;
        int cyc;
        for (int n = 0; n < max; n++) begin
            ins = rmem[rpc];
            op  = ins[7:5];
            opd = {3'b000, ins[4:0]};
            chk("fetch_addr", memAddr, rpc);
            if (op == 3'd7) begin
                tick();
                tick();
                chk("halt_flag", halted, 1);
                run = 1'b1;
                repeat (3) tick();
                run = 1'b0;
                chk("halt_hold_flag", halted, 1);
                chk("halt_pc", pc, rpc);
                chk("halt_acc", acc, racc);
                chk("halt_wr", memWrite, 0);
                chk("halt_addr", memAddr, 0);
                chk("halt_writes", wr_count, wexp);
                return;
            end
            cyc  = (op inside {3'd0, 3'd1, 3'd3, 3'd4}) ? 4 : 3;
            ectl = (op == 3'd1) ? 2'b01 : (op == 3'd2) ? 2'b10 : (op == 3'd3) ? 2'b11 : 2'b00;
            repeat (cyc - 1) tick();
            chk("exec_aluctl", aluControl, ectl);
            chk("exec_wr", memWrite, (op == 3'd5));
            if (op == 3'd5) begin
                chk("store_addr", memAddr, opd);
                chk("store_data", memWriteData, racc);
            end
            if (op == 3'd2) chk("bnz_operand", aluDataIn, opd);
            case (op)
                3'd0: racc = racc + rmem[opd];
                3'd1: racc = ~(racc & rmem[opd]);
                3'd3: racc = (racc < rmem[opd]) ? 8'd1 : 8'd0;
                3'd4: racc = rmem[opd];
                3'd5: begin rmem[opd] = racc; wexp++; end
                3'd6: racc = opd;
                default: ;
            endcase
            if (op == 3'd2) rpc = (racc != 8'd0) ? opd : rpc + 8'd1;
            else            rpc = rpc + 8'd1;
            tick();
            chk("pc", pc, rpc);
            chk("acc", acc, racc);
            chk("writes", wr_count, wexp);
        end
    endtask

    initial begin
        int w0;
        fill(8'h00);

        // Reset state and idle behaviour without run.
        do_reset();
        chk("rst_pc", pc, 0);
        chk("rst_acc", acc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_wr", memWrite, 0);
        chk("rst_aluctl", aluControl, 0);
        chk("rst_addr", memAddr, 0);
        repeat (3) tick();
        chk("idle_pc", pc, 0);
        chk("idle_addr", memAddr, 0);

        // LDI 5; ADD 20 (mem[20]=3); HALT.
        fill(8'h00);
        put(0, 8'hC5); put(1, 8'h14); put(20, 8'h03); put(2, 8'hE0);
        do_reset(); start();
        exec_prog(10);
        chk("ldi_add_acc", acc, 8'h08);
        chk("ldi_add_pc", pc, 8'h02);

        // BNZ 10 at pc 4 with acc=0, then again with acc=1.
        fill(8'h00);
        for (int i = 0; i < 4; i++) put(i, 8'hC0);
        put(4, 8'h4A); put(5, 8'hC1); put(6, 8'h44); put(10, 8'hE0);
        do_reset(); start();
        exec_prog(20);
        chk("bnz_taken_pc", pc, 8'h0A);

        // SLT true then false.
        fill(8'h00);
        put(0, 8'hC2); put(1, 8'h68); put(8, 8'h07);
        put(2, 8'hC2); put(3, 8'h69); put(9, 8'h01); put(4, 8'hE0);
        do_reset(); start();
        exec_prog(10);
        chk("slt_false_acc", acc, 8'h00);

        // LOAD A5; STORE 31.
        fill(8'h00);
        put(30, 8'hA5); put(0, 8'h9E); put(1, 8'hBF); put(2, 8'hE0);
        wexp = wr_count;
        do_reset(); start();
        exec_prog(10);
        chk("store_mem", mem[31], 8'hA5);

        // PC wraps from FF to 00.
        fill(8'hC1);
        put(255, 8'hC0);
        do_reset(); start();
        exec_prog(256);
        chk("wrap_pc", pc, 8'h00);
        chk("wrap_acc", acc, 8'h00);

        // Reset during READ of an ADD.
        fill(8'h00);
        put(0, 8'hC5); put(1, 8'h14); put(20, 8'h03);
        do_reset(); start();
        repeat (5) tick();
        chk("read_addr", memAddr, 8'd20);
        chk("read_aluctl", aluControl, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rr_pc", pc, 0);
        chk("rr_acc", acc, 0);
        chk("rr_wr", memWrite, 0);
        chk("rr_addr", memAddr, 0);
        chk("rr_halted", halted, 0);
        repeat (2) tick();
        chk("rr_idle_addr", memAddr, 0);

        // Reset during the STORE EXEC cycle: exactly one write.
        fill(8'h00);
        put(0, 8'hC7); put(1, 8'hA3);
        do_reset(); start();
        repeat (5) tick();
        chk("rs_wr_high", memWrite, 1);
        w0 = wr_count;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_wr_low", memWrite, 0);
        repeat (3) tick();
        chk("rs_writes", wr_count, w0 + 1);
        chk("rs_mem", mem[3], 8'h07);

        // Random programs.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 256; i++) put(i, 8'($urandom));
            wexp = wr_count;
            do_reset(); start();
            exec_prog(40);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
